// File: rtl/pcs25g_gray12_pkg.sv
// Shared constants and helpers for the 12-entry PCS 25G elastic buffer controller.
// Defines the mod-12 Gray code sequence, its successor function and its Gray-to-index decode.
package pcs25g_gray12_pkg;

  localparam int DEPTH = 12;

  // Mod-12 Gray sequence; the wrap from G11 back to G0 also flips a single bit.
  localparam logic [3:0] G0  = 4'b0000;
  localparam logic [3:0] G1  = 4'b0001;
  localparam logic [3:0] G2  = 4'b0011;
  localparam logic [3:0] G3  = 4'b0010;
  localparam logic [3:0] G4  = 4'b0110;
  localparam logic [3:0] G5  = 4'b0111;
  localparam logic [3:0] G6  = 4'b0101;
  localparam logic [3:0] G7  = 4'b0100;
  localparam logic [3:0] G8  = 4'b1100;
  localparam logic [3:0] G9  = 4'b1101;
  localparam logic [3:0] G10 = 4'b1001;
  localparam logic [3:0] G11 = 4'b1000;

  function automatic logic [3:0] gray12_next(input logic [3:0] g);
    case (g)
      G0:      return G1;
      G1:      return G2;
      G2:      return G3;
      G3:      return G4;
      G4:      return G5;
      G5:      return G6;
      G6:      return G7;
      G7:      return G8;
      G8:      return G9;
      G9:      return G10;
      G10:     return G11;
      G11:     return G0;
      default: return G0;
    endcase
  endfunction

  function automatic logic [3:0] gray12_to_bin(input logic [3:0] g);
    case (g)
      G0:      return 4'd0;
      G1:      return 4'd1;
      G2:      return 4'd2;
      G3:      return 4'd3;
      G4:      return 4'd4;
      G5:      return 4'd5;
      G6:      return 4'd6;
      G7:      return 4'd7;
      G8:      return 4'd8;
      G9:      return 4'd9;
      G10:     return 4'd10;
      G11:     return 4'd11;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/pcs25g_gray12_elastic_ctrl_ptr.sv
// Enable-gated mod-12 Gray pointer register (module pcs25g_gray12_ptr).
// Exposes the Gray code and its binary RAM index; synchronous active-low reset to G0.
module pcs25g_gray12_ptr
  import pcs25g_gray12_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en_i,
  output logic [3:0] gray_o,
  output logic [3:0] idx_o
);

  logic [3:0] gray_q;
  logic [3:0] gray_d;

  always_comb begin
    gray_d = en_i ? gray12_next(gray_q) : gray_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) gray_q <= G0;
    else          gray_q <= gray_d;
  end

  assign gray_o = gray_q;
  assign idx_o  = gray12_to_bin(gray_q);

endmodule

// File: rtl/pcs25g_gray12_elastic_ctrl.sv
// Pointer/flow controller for the 12-entry PCS 25G elastic buffer (storage RAM is external).
// Define PCS25G_ELASTIC_RC_EN to enable clock-compensation idle deletion and insertion.
module pcs25g_gray12_elastic_ctrl
  import pcs25g_gray12_pkg::*;
#(
  parameter int HI_WM = 9,
  parameter int LO_WM = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_valid,
  input  logic       wr_del_ok,
  output logic       wr_ready,
  output logic       ram_we,
  output logic [3:0] ram_waddr,
  input  logic       rd_ready,
  input  logic       rd_idle_ok,
  output logic       rd_valid,
  output logic       rd_ins,
  output logic [3:0] ram_raddr,
  output logic [3:0] wr_gray,
  output logic [3:0] rd_gray,
  output logic [3:0] level,
  output logic       full,
  output logic       empty,
  output logic       rc_del,
  output logic       rc_ins
);

  logic [3:0] level_q, level_d;
  logic       rc_del_q, rc_ins_q;
  logic       del, ins, push, pop;

  assign full  = (level_q == 4'(DEPTH));
  assign empty = (level_q == 4'd0);

`ifdef PCS25G_ELASTIC_RC_EN
  assign del = reset_n & wr_valid & wr_del_ok & (level_q >= 4'(HI_WM)) & ~full;
  assign ins = reset_n & rd_ready & rd_idle_ok & (level_q <= 4'(LO_WM));
`else
  logic unused_rc;
  assign del       = 1'b0;
  assign ins       = 1'b0;
  assign unused_rc = &{1'b0, wr_del_ok, rd_idle_ok, 4'(HI_WM), 4'(LO_WM)};
`endif

  // Handshake outputs are forced low while reset is asserted.
  assign wr_ready = reset_n & ~full;
  assign push     = wr_valid & wr_ready & ~del;
  assign pop      = reset_n & rd_ready & ~empty & ~ins;
  assign ram_we   = push;
  assign rd_valid = reset_n & (ins | ~empty);
  assign rd_ins   = ins;

  pcs25g_gray12_ptr u_wr_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (push),
    .gray_o  (wr_gray),
    .idx_o   (ram_waddr)
  );

  pcs25g_gray12_ptr u_rd_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (pop),
    .gray_o  (rd_gray),
    .idx_o   (ram_raddr)
  );

  // NOTE: assign a default before the case so every path drives level_d and no latch is inferred.
  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 4'd1;
      2'b01:   level_d = level_q - 4'd1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      level_q  <= 4'd0;
      rc_del_q <= 1'b0;
      rc_ins_q <= 1'b0;
    end else begin
      level_q  <= level_d;
      rc_del_q <= del;
      rc_ins_q <= ins;
    end
  end

  assign level  = level_q;
  assign rc_del = rc_del_q;
  assign rc_ins = rc_ins_q;

endmodule
